sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Pixel-streaming draw engine between the game FSMs and the 160x120 VGA adapter.
- Accepts one rectangle request at a time over a valid/ready handshake: a garbage or press sprite, drawn or erased, at a position.
- Emits one pixel per clock (x, y, colour, plot), then pulses done.
- Replaces the game FSMs' fixed wait counters with an explicit completion handshake.

Parameters:
- LANE_W, 40, lane width in pixels (4 lanes across 160)
- GARB_W, 20, garbage width
- GARB_H, 20, garbage height
- GARB_XOFF, 10, garbage x offset inside lane
- GARB_Y, 100, garbage top row
- PRESS_W, 40, press width
- PRESS_H, 60, press height
- PRESS_Y, 0, press top row
- GARB_COL, 3'b010, garbage colour (green)
- PRESS_COL, 3'b111, press colour (white)
- ERASE_COL, 3'b000, erase colour (black)

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle, able to accept
- req_item  in  1  0 = garbage, 1 = press
- req_erase  in  1  1 = paint ERASE_COL instead of the sprite colour
- req_position  in  3  garbage 0..3; press 0..5
- x  out  8  pixel column to VGA
- y  out  7  pixel row to VGA
- colour  out  3  pixel colour to VGA
- plot  out  1  write strobe to VGA
- busy  out  1  high in DRAW or DONE
- done  out  1  one-cycle pulse after the last pixel
- error  out  1  one-cycle pulse on an invalid request

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (resetn). All state changes happen on posedge clock.
- Reset values: x=0, y=0, colour=0, plot=0, done=0, error=0, busy=0, state=IDLE, so req_ready=1 once resetn is released.
- Registered outputs: x, y, colour, plot, done, error. req_ready and busy are decoded from state.
- States: IDLE, DRAW, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch item, erase and position.
  - Valid request: go to DRAW.
  - Invalid request (item=0 with position>3, or position>5): pulse error for one cycle, stay in IDLE, never plot.
- Lane mapping:
  - Garbage: lane = position.
  - Press: lane = position for 0..3, and 6-position for 4..5, giving lanes 0,1,2,3,2,1.
- Geometry:
  - Garbage: x = lane*LANE_W + GARB_XOFF + col, y = GARB_Y + row; col 0..GARB_W-1, row 0..GARB_H-1.
  - Press: x = lane*LANE_W + col, y = PRESS_Y + row; col 0..PRESS_W-1, row 0..PRESS_H-1.
- DRAW:
  - Raster order: col increments first, then row.
  - One pixel per cycle with plot=1.
  - colour = ERASE_COL if erase is set, otherwise the item colour.
  - After the last pixel (col=W-1, row=H-1) go to DONE.
- DONE: done=1 and plot=0 for one cycle, then IDLE.
- Latency, with acceptance at cycle 0:
  - first plot at cycle 1;
  - last plot at cycle N (N=400 for garbage, N=2400 for press);
  - done at N+1;
  - req_ready high again at N+2.
- Requests while busy: req_ready=0, so req_valid is ignored and nothing is queued.
- Arithmetic: col and row counters are 6 bits; coordinate sums are computed in 8/7 bits. All parameter-legal values stay within 159/119, so there is no wrap.
- Reset mid-draw: plot drops to 0 immediately (asynchronous). No done pulse. Counters clear. Return to IDLE.
- req_item, req_erase and req_position may change during DRAW; only the values latched at acceptance are used.

Decomposition:
- Shared package sprite_pkg:
  - lane, sprite and colour constants;
  - item encoding (ITEM_GARB=0, ITEM_PRESS=1);
  - press lane sequence constant (max position 5).
- One sub-module: rect_scanner.
  - Inputs: start, width, height.
  - Outputs: col, row, active, last.
  - Implements the raster counters.
  - sprite_blitter keeps the handshake FSM, lane mapping and colour select.

Test Plan:
- Garbage draw, pos 2, erase 0: plot 1 at cycle 1 with (90,100) colour 3'b010; last plot (109,119) at cycle 400; exactly 400 plots; done at cycle 401; req_ready=1 at 402.
- Press draw, pos 4: lane 2; x spans 80..119, y spans 0..59, colour 3'b111; 2400 plots; done at cycle 2401.
- Press erase, pos 5: lane 1; first pixel (40,0), last pixel (79,59), all colour 3'b000.
- Invalid request item=0, pos=3'b100: error pulse for one cycle; plot stays 0; req_ready remains 1; done never asserts.
- Second request pulsed at cycle 50 of a garbage draw: ignored (req_ready=0); pixel count still 400; only one done pulse.
- Reset asserted at pixel 150 of a press draw: plot=0 the same cycle; no done; after release req_ready=1 and a new pos 0 garbage request draws correctly, first pixel (10,100).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and helpers for the sprite blitter: lane geometry, sprite sizes,
// colours, item encoding and the press lane sequence.
package sprite_pkg;

    localparam int unsigned LANE_W    = 40;
    localparam int unsigned GARB_W    = 20;
    localparam int unsigned GARB_H    = 20;
    localparam int unsigned GARB_XOFF = 10;
    localparam int unsigned GARB_Y    = 100;
    localparam int unsigned PRESS_W   = 40;
    localparam int unsigned PRESS_H   = 60;
    localparam int unsigned PRESS_Y   = 0;

    localparam logic [2:0] GARB_COL  = 3'b010;
    localparam logic [2:0] PRESS_COL = 3'b111;
    localparam logic [2:0] ERASE_COL = 3'b000;

    localparam logic ITEM_GARB  = 1'b0;
    localparam logic ITEM_PRESS = 1'b1;

    localparam logic [2:0] GARB_POS_MAX  = 3'd3;
    localparam logic [2:0] PRESS_POS_MAX = 3'd5;

    // Press lane for position i lives in bits [2i+1:2i]: lanes 0,1,2,3,2,1.
    localparam logic [11:0] PRESS_LANE_SEQ = {2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

    typedef enum logic [1:0] {StIdle, StDraw, StDone} blit_state_e;

    function automatic logic req_ok(input logic item, input logic [2:0] pos);
        return (item == ITEM_PRESS) ? (pos <= PRESS_POS_MAX) : (pos <= GARB_POS_MAX);
    endfunction

    function automatic logic [1:0] lane_of(input logic item, input logic [2:0] pos);
        logic [2:0] idx;
        idx = (pos > PRESS_POS_MAX) ? 3'd0 : pos;
        if (item == ITEM_PRESS) begin
            return PRESS_LANE_SEQ[{idx, 1'b0} +: 2];
        end
        return pos[1:0];
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster counter over a width x height rectangle, column first. start presents
// pixel (0,0) in the same cycle so the caller can register it immediately.
module rect_scanner (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [5:0] width,
    input  logic [5:0] height,
    output logic [5:0] col,
    output logic [5:0] row,
    output logic       active,
    output logic       last
);

    logic [5:0] col_q, col_d;
    logic [5:0] row_q, row_d;
    logic       active_q, active_d;

    assign active = start | active_q;
    assign col    = start ? 6'd0 : col_q;
    assign row    = start ? 6'd0 : row_q;
    assign last   = active && (col == width - 6'd1) && (row == height - 6'd1);

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        active_d = active_q;
        if (active) begin
            if (last) begin
                col_d    = 6'd0;
                row_d    = 6'd0;
                active_d = 1'b0;
            end else if (col == width - 6'd1) begin
                col_d    = 6'd0;
                row_d    = row + 6'd1;
                active_d = 1'b1;
            end else begin
                col_d    = col + 6'd1;
                row_d    = row;
                active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_q    <= 6'd0;
            row_q    <= 6'd0;
            active_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Streams one garbage or press rectangle per request to the VGA adapter, one pixel
// per clock, then pulses done; invalid requests pulse error without drawing.
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_item,
    input  logic       req_erase,
    input  logic [2:0] req_position,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       error
);

    blit_state_e state_q, state_d;
    logic        item_q, erase_q;
    logic [2:0]  pos_q;
    logic        last_q;
    logic [7:0]  x_d;
    logic [6:0]  y_d;
    logic [2:0]  colour_d;
    logic        plot_d, done_d, error_d;

    logic        idle, start;
    logic        cur_item, cur_erase;
    logic [2:0]  cur_pos;
    logic [1:0]  lane;
    logic [5:0]  width, height, col, row;
    logic        scan_active, scan_last;
    logic [7:0]  x_org, pix_x;
    logic [6:0]  y_org, pix_y;
    logic [2:0]  pix_col;

    assign idle      = (state_q == StIdle);
    assign req_ready = idle;
    assign busy      = !idle;
    assign start     = idle && req_valid && req_ok(req_item, req_position);

    // The first pixel is registered on the accept edge, so geometry comes straight
    // from the request while idle and from the latched copy afterwards.
    assign cur_item  = idle ? req_item : item_q;
    assign cur_erase = idle ? req_erase : erase_q;
    assign cur_pos   = idle ? req_position : pos_q;

    assign lane    = lane_of(cur_item, cur_pos);
    assign width   = (cur_item == ITEM_PRESS) ? 6'(PRESS_W) : 6'(GARB_W);
    assign height  = (cur_item == ITEM_PRESS) ? 6'(PRESS_H) : 6'(GARB_H);
    assign x_org   = 8'(lane) * 8'(LANE_W) + ((cur_item == ITEM_PRESS) ? 8'd0 : 8'(GARB_XOFF));
    assign y_org   = (cur_item == ITEM_PRESS) ? 7'(PRESS_Y) : 7'(GARB_Y);
    assign pix_x   = x_org + 8'(col);
    assign pix_y   = y_org + 7'(row);
    assign pix_col = cur_erase ? ERASE_COL : ((cur_item == ITEM_PRESS) ? PRESS_COL : GARB_COL);

    rect_scanner u_scanner (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .width  (width),
        .height (height),
        .col    (col),
        .row    (row),
        .active (scan_active),
        .last   (scan_last)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (start) state_d = StDraw;
                    else       error_d = 1'b1;
                end
            end
            StDraw: begin
                // last_q: the final pixel is on the output registers this cycle.
                if (last_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (scan_active) begin
            plot_d   = 1'b1;
            x_d      = pix_x;
            y_d      = pix_y;
            colour_d = pix_col;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            item_q  <= ITEM_GARB;
            erase_q <= 1'b0;
            pos_q   <= 3'd0;
            last_q  <= 1'b0;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= scan_last;
            x       <= x_d;
            y       <= y_d;
            colour  <= colour_d;
            plot    <= plot_d;
            done    <= done_d;
            error   <= error_d;
            if (start) begin
                item_q  <= req_item;
                erase_q <= req_erase;
                pos_q   <= req_position;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table of requests with a pixel scoreboard,
// plus a hand-written mid-draw reset sequence.
module tb_sprite_blitter;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_item = 1'b0;
    logic       req_erase = 1'b0;
    logic [2:0] req_position = 3'd0;
    logic       req_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done, error;

    sprite_blitter dut (
        .clock        (clock),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_item     (req_item),
        .req_erase    (req_erase),
        .req_position (req_position),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic       item;
        logic       erase;
        logic [2:0] pos;
        logic       err;
        int         n;
        int         inject;
        int         x0, y0, xl, yl;
        logic [2:0] col;
    } vec_t;

    vec_t        vecs[7];
    vec_t        after_reset;
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endfunction

    // Independent reference: enumerate every pixel the request should produce.
    task automatic push_model(input logic item, input logic erase, input logic [2:0] pos);
        int lane, w, h, xo, yo, c;
        lane = item ? ((pos < 4) ? int'(pos) : 6 - int'(pos)) : int'(pos);
        w    = item ? 40 : 20;
        h    = item ? 60 : 20;
        xo   = lane * 40 + (item ? 0 : 10);
        yo   = item ? 0 : 100;
        c    = erase ? 0 : (item ? 7 : 2);
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                exp_q.push_back({8'(xo + cc), 7'(yo + r), 3'(c)});
            end
        end
    endtask

    task automatic check_pixel();
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel_extra: got %0d expected none", {x, y, colour});
        end else begin
            e = exp_q.pop_front();
            chk("pixel", int'({x, y, colour}), int'(e));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int plots, dones, errs, first_k, last_k, done_k, fx, fy, fc, lx, ly, budget;
        plots = 0; dones = 0; errs = 0; first_k = 0; last_k = 0; done_k = 0;
        fx = 0; fy = 0; fc = 0; lx = 0; ly = 0;
        if (!v.err) push_model(v.item, v.erase, v.pos);
        chk("ready_idle", req_ready, 1);
        req_item     = v.item;
        req_erase    = v.erase;
        req_position = v.pos;
        req_valid    = 1'b1;
        @(posedge clock);
        #1;
        req_valid    = 1'b0;
        req_item     = ~v.item;
        req_erase    = ~v.erase;
        req_position = 3'd7;
        budget = v.err ? 8 : v.n + 8;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            if (k == 1) chk("busy_first", busy, v.err ? 0 : 1);
            if (v.inject != 0 && k == v.inject) begin
                chk("ready_while_busy", req_ready, 0);
                req_valid    = 1'b1;
                req_item     = 1'b0;
                req_erase    = 1'b0;
                req_position = 3'd1;
            end
            if (v.inject != 0 && k == v.inject + 1) req_valid = 1'b0;
            if (plot) begin
                plots++;
                if (plots == 1) begin
                    fx = x; fy = y; fc = colour; first_k = k;
                end
                lx = x; ly = y; last_k = k;
                check_pixel();
            end
            if (done) begin
                dones++;
                done_k = k;
            end
            if (error) errs++;
            if (dones > 0 && k == done_k + 1) begin
                chk("ready_after_done", req_ready, 1);
                break;
            end
        end
        chk("plot_count", plots, v.n);
        chk("done_count", dones, v.err ? 0 : 1);
        chk("error_count", errs, v.err ? 1 : 0);
        chk("queue_left", exp_q.size(), 0);
        chk("ready_end", req_ready, 1);
        if (!v.err) begin
            chk("first_cycle", first_k, 1);
            chk("last_cycle", last_k, v.n);
            chk("done_cycle", done_k, v.n + 1);
            chk("first_x", fx, v.x0);
            chk("first_y", fy, v.y0);
            chk("first_colour", fc, int'(v.col));
            chk("last_x", lx, v.xl);
            chk("last_y", ly, v.yl);
        end
        exp_q.delete();
    endtask

    initial begin
        int plots, dones;
        vecs[0] = '{item: 0, erase: 0, pos: 2, err: 0, n: 400, inject: 0,
                    x0: 90, y0: 100, xl: 109, yl: 119, col: 3'b010};
        vecs[1] = '{item: 1, erase: 0, pos: 4, err: 0, n: 2400, inject: 0,
                    x0: 80, y0: 0, xl: 119, yl: 59, col: 3'b111};
        vecs[2] = '{item: 1, erase: 1, pos: 5, err: 0, n: 2400, inject: 0,
                    x0: 40, y0: 0, xl: 79, yl: 59, col: 3'b000};
        vecs[3] = '{item: 0, erase: 0, pos: 4, err: 1, n: 0, inject: 0,
                    x0: 0, y0: 0, xl: 0, yl: 0, col: 3'b000};
        vecs[4] = '{item: 0, erase: 0, pos: 2, err: 0, n: 400, inject: 50,
                    x0: 90, y0: 100, xl: 109, yl: 119, col: 3'b010};
        vecs[5] = '{item: 1, erase: 0, pos: 6, err: 1, n: 0, inject: 0,
                    x0: 0, y0: 0, xl: 0, yl: 0, col: 3'b000};
        vecs[6] = '{item: 0, erase: 1, pos: 3, err: 0, n: 400, inject: 0,
                    x0: 130, y0: 100, xl: 149, yl: 119, col: 3'b000};
        after_reset = '{item: 0, erase: 0, pos: 0, err: 0, n: 400, inject: 0,
                        x0: 10, y0: 100, xl: 29, yl: 119, col: 3'b010};

        repeat (3) @(negedge clock);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        @(negedge clock);
        chk("rst_ready", req_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            @(negedge clock);
        end

        // Press draw interrupted by reset at pixel 150.
        push_model(1'b1, 1'b0, 3'd0);
        req_item = 1'b1; req_erase = 1'b0; req_position = 3'd0; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        plots = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            if (plot) begin
                plots++;
                check_pixel();
            end
            if (plots == 150) break;
        end
        chk("plots_before_reset", plots, 150);
        resetn = 1'b0;
        #1;
        chk("reset_plot", plot, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_x", x, 0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        dones = 0;
        plots = 0;
        repeat (5) begin
            @(negedge clock);
            if (done) dones++;
            if (plot) plots++;
        end
        chk("post_reset_done", dones, 0);
        chk("post_reset_plots", plots, 0);
        chk("post_reset_ready", req_ready, 1);
        run_vec(after_reset);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
